rego_uart_tx: RTL and testbench

REGO_UART_TX -- requirements
Module: rego_uart_tx

---
 rtl/rego_uart_tx.sv | 140 ++++++++++++++
 tb/tb_rego_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rego_uart_tx.sv
// rtl/rego_uart_tx.sv - streams each change of a 4-bit register as an ASCII hex digit over an 8N1 UART.
module rego_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] regO,
  output logic       tx,
  output logic       busy,
  output logic [4:0] level,
  output logic       overflow
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx;
  logic          bit_done;

  logic [3:0]    last_val;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          change, push_ok, pop;
  logic [7:0]    push_byte;

  assign change  = (regO != last_val);
  assign push_ok = change && ((level < DEPTH5) || pop);

  always_comb begin
    if (regO < 4'd10) push_byte = 8'h30 + {4'h0, regO};
    else              push_byte = 8'h37 + {4'h0, regO};
  end

  // Storage has no reset: resetting the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_val <= 4'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      last_val <= regO;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (change && !push_ok) overflow <= 1'b1;
    end
  end

  assign bit_done = (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (level != 5'd0) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          state_nx = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_nx   = '0;
          idx_nx   = 3'd0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nx = '0;
          if (idx == 3'd7) state_nx = STOP;
          else             idx_nx   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_nx = '0;
          // Chain straight into the next frame so queued bytes leave without an idle gap.
          if (level != 5'd0) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[idx_nx];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      tx    <= tx_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rego_uart_tx.sv
// tb/tb_rego_uart_tx.sv - self-checking bench for rego_uart_tx with a frame-level reference model.
module tb_rego_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] regO;
  logic       tx, busy, overflow;
  logic [4:0] level;

  rego_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .regO(regO),
    .tx(tx), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [7:0] code;
    int         frames;
  } vec_t;

  int checks = 0;
  int passed = 0;

  // Reference model: queue of pending bytes plus a countdown of cycles left in the current frame.
  logic [3:0] m_last;
  logic [7:0] m_q[$];
  logic [7:0] exp_sent[$];
  logic [7:0] m_cur;
  int         m_left;
  bit         m_ovf;

  logic [7:0] rx_q[$];
  logic [7:0] dec_byte;
  bit         dec_on;
  int         dec_t;
  int         dut_peak, busy_cnt, busy_rises;
  logic       busy_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] asc(input logic [3:0] v);
    return (v < 10) ? 8'(48 + int'(v)) : 8'(65 + int'(v) - 10);
  endfunction

  function automatic logic m_tx();
    int pos;
    if (m_left == 0) return 1'b1;
    pos = (FRAME - m_left) / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_last = 4'h0; m_q.delete(); m_left = 0; m_cur = 8'h00; m_ovf = 0;
  endtask

  task automatic model_step();
    if (!resetn) begin
      model_clear();
      return;
    end
    if (m_left <= 1 && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      exp_sent.push_back(m_cur);
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (regO != m_last) begin
      if (m_q.size() < DEPTH) m_q.push_back(asc(regO));
      else m_ovf = 1;
    end
    m_last = regO;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle tx/busy/level/ovf", {tx, busy, level, overflow},
          {m_tx(), (m_left > 0), 5'(m_q.size()), m_ovf});
    if (int'(level) > dut_peak) dut_peak = int'(level);
    if (busy) busy_cnt++;
    if (busy && !busy_prev) busy_rises++;
    busy_prev = busy;
    if (!dec_on) begin
      if (resetn && tx == 1'b0) begin dec_on = 1; dec_t = 0; end
    end else begin
      dec_t++;
      if (dec_t % CPB == CPB / 2 && dec_t / CPB >= 1 && dec_t / CPB <= 8)
        dec_byte[dec_t/CPB-1] = tx;
      if (dec_t == 9 * CPB + CPB / 2) begin
        check("stop bit", tx, 1);
        rx_q.push_back(dec_byte);
        dec_on = 0;
      end
    end
  endtask

  task automatic release_reset();
    resetn = 1'b1; regO = 4'h0;
    rx_q.delete(); exp_sent.delete();
    dec_on = 0; dec_t = 0; dut_peak = 0; busy_cnt = 0; busy_rises = 0; busy_prev = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_clear();
    repeat (3) tick();
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset level", level, 0);
    check("reset overflow", overflow, 0);
    release_reset();
  endtask

  task automatic compare_sent(input string name);
    check({name, " count vs model"}, rx_q.size(), exp_sent.size());
    for (int i = 0; i < rx_q.size() && i < exp_sent.size(); i++)
      check({name, " byte vs model"}, rx_q[i], exp_sent[i]);
  endtask

  initial begin
    vec_t       vecs[17];
    logic [7:0] want[$];
    string      hs;
    logic [3:0] v;

    resetn = 1'b0; regO = 4'h0;
    hs = "0123456789ABCDEF";
    for (int i = 0; i < 10; i++) vecs[i] = '{4'(i), 8'h30 + 8'(i), 1};
    vecs[10] = '{4'hA, 8'h41, 1}; vecs[11] = '{4'hB, 8'h42, 1};
    vecs[12] = '{4'hC, 8'h43, 1}; vecs[13] = '{4'hD, 8'h44, 1};
    vecs[14] = '{4'hE, 8'h45, 1}; vecs[15] = '{4'hF, 8'h46, 1};
    vecs[16] = '{4'h0, 8'h00, 0};
    vecs[0].frames = 0;

    do_reset();
    repeat (50) tick();
    check("zero after reset sends nothing", rx_q.size(), 0);

    for (int i = 0; i < 17; i++) begin
      do_reset();
      regO = vecs[i].val;
      repeat (48) tick();
      check("table frame count", rx_q.size(), vecs[i].frames);
      if (vecs[i].frames == 1 && rx_q.size() == 1) check("table byte", rx_q[0], vecs[i].code);
      check("table busy cycles", busy_cnt, 40 * vecs[i].frames);
      repeat (50) tick();
      check("held value no refire", rx_q.size(), vecs[i].frames);
      compare_sent("table");
    end

    do_reset();
    regO = 4'h1; tick(); regO = 4'h2; tick(); regO = 4'h3; tick();
    repeat (130) tick();
    check("b2b peak level", dut_peak, 2);
    check("b2b frames", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++) check("b2b byte", rx_q[i], 8'h31 + 8'(i));
    check("b2b busy cycles", busy_cnt, 120);
    check("b2b no idle gap", busy_rises, 1);
    compare_sent("b2b");

    do_reset();
    for (int i = 0; i < 12; i++) begin
      regO = (i % 2 == 1) ? 4'h2 : 4'h1;
      tick();
    end
    repeat (400) tick();
    check("ovf peak level", dut_peak, 8);
    check("ovf flag", overflow, 1);
    check("ovf frames", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check("ovf byte", rx_q[i], (i % 2 == 1) ? 8'h32 : 8'h31);
    compare_sent("ovf");

    do_reset();
    regO = 4'h5; tick(); regO = 4'h6; tick(); regO = 4'h7; tick();
    for (int n = 0; n < 100 && m_left != FRAME - 4 * CPB - 1; n++) tick();
    check("reached data bit 3", m_left, FRAME - 4 * CPB - 1);
    resetn = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset level", level, 0);
    check("async reset busy", busy, 0);
    model_clear();
    repeat (3) tick();
    release_reset();
    repeat (60) tick();
    check("no frame after mid reset", rx_q.size(), 0);
    check("no busy after mid reset", busy_cnt, 0);

    do_reset();
    want.delete();
    v = 4'h0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] nv;
      nv = 4'($urandom_range(0, 15));
      if (nv == v) nv = nv + 4'h1;
      v = nv; regO = v;
      want.push_back(hs[int'(v)]);
      repeat (42) tick();
    end
    repeat (10) tick();
    check("wrap peak <= 1", (dut_peak <= 1), 1);
    check("wrap overflow", overflow, 0);
    check("wrap frames", rx_q.size(), 20);
    for (int i = 0; i < 20 && i < rx_q.size(); i++) check("wrap byte", rx_q[i], want[i]);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) regO = 4'($urandom_range(0, 15));
      tick();
    end
    repeat (500) tick();
    compare_sent("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
